// File: rtl/n64_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module   : n64_cmd_tx
//  Purpose  : N64 joybus command transmitter. Serialises 1..MAX_BYTES bytes
//             (byte 0 first, each MSB first) followed by the console stop bit.
//             Each data bit is 4 chips: '0' = L L L H, '1' = L H H H.
//             The stop bit is L H. Each chip lasts CLKS_PER_CHIP clocks.
//  Ports    : clk, reset (sync, active-high)
//             start          - pulse: latch cmd_data/cmd_len and begin a frame
//             cmd_data       - byte k at [8k+7:8k]
//             cmd_len        - byte count, 1..MAX_BYTES
//             busy/enable_o  - high for every chip of the frame
//             dout           - registered line level (1 when idle)
//             done           - 1-cycle pulse after the last chip
//             err            - 1-cycle pulse when start had a bad cmd_len
//  Revision : 1.0 - initial release
// ============================================================================
module n64_cmd_tx #(
    parameter int MAX_BYTES     = 3,
    parameter int CLKS_PER_CHIP = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [8*MAX_BYTES-1:0]           cmd_data,
    input  logic [$clog2(MAX_BYTES+1)-1:0]   cmd_len,
    output logic                             busy,
    output logic                             enable_o,
    output logic                             dout,
    output logic                             done,
    output logic                             err
);

    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int BW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int PW = (CLKS_PER_CHIP > 1) ? $clog2(CLKS_PER_CHIP) : 1;
    localparam int NB = 1 << BW;

    localparam logic [LW-1:0] c_MAX_LEN  = LW'(MAX_BYTES);
    localparam logic [PW-1:0] c_PRE_LAST = PW'(CLKS_PER_CHIP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BITS = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t                 r_state, w_state_n;
    logic [8*MAX_BYTES-1:0] r_data;
    logic [BW-1:0]          r_last;          // index of the final byte
    logic [PW-1:0]          r_pre,  w_pre_n;
    logic [1:0]             r_chip, w_chip_n;
    logic [2:0]             r_bit,  w_bit_n;  // 0 = MSB of current byte
    logic [BW-1:0]          r_byte, w_byte_n;
    logic                   r_en,   w_en_n;
    logic                   r_dout, w_dout_n;
    logic                   r_done, w_done_n;
    logic                   r_err,  w_err_n;
    logic                   w_latch;
    logic                   w_len_ok;
    logic                   w_pre_last;
    logic [7:0]             w_bytes [NB];
    logic [7:0]             w_cur_byte;
    logic                   w_cur_bit;

    // Byte table padded to a power of two so any byte-counter value indexes
    // a defined entry.
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        if (gi < MAX_BYTES) begin : g_real
            assign w_bytes[gi] = r_data[8*gi +: 8];
        end else begin : g_pad
            assign w_bytes[gi] = 8'h00;
        end
    end

    assign w_cur_byte = w_bytes[r_byte];
    assign w_cur_bit  = w_cur_byte[~r_bit];   // ~r_bit == 7 - r_bit
    assign w_len_ok   = (cmd_len != '0) && (cmd_len <= c_MAX_LEN);
    assign w_pre_last = (r_pre == c_PRE_LAST);

    // Next-state logic. The line level is computed for the chip about to be
    // entered so that dout leaves the register aligned with enable_o.
    always_comb begin
        w_state_n = r_state;
        w_pre_n   = r_pre;
        w_chip_n  = r_chip;
        w_bit_n   = r_bit;
        w_byte_n  = r_byte;
        w_en_n    = r_en;
        w_dout_n  = r_dout;
        w_done_n  = 1'b0;
        w_err_n   = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_en_n   = 1'b0;
                w_dout_n = 1'b1;
                if (start) begin
                    if (w_len_ok) begin
                        w_latch   = 1'b1;
                        w_state_n = S_BITS;
                        w_en_n    = 1'b1;
                        w_dout_n  = 1'b0;
                        w_pre_n   = '0;
                        w_chip_n  = 2'd0;
                        w_bit_n   = 3'd0;
                        w_byte_n  = '0;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            S_BITS: begin
                if (w_pre_last) begin
                    w_pre_n = '0;
                    if (r_chip == 2'd3) begin
                        w_chip_n = 2'd0;
                        w_dout_n = 1'b0;         // chip 0 of any bit is low
                        if (r_bit == 3'd7) begin
                            w_bit_n = 3'd0;
                            if (r_byte == r_last) begin
                                w_byte_n  = '0;
                                w_state_n = S_STOP;
                            end else begin
                                w_byte_n = r_byte + 1'b1;
                            end
                        end else begin
                            w_bit_n = r_bit + 3'd1;
                        end
                    end else begin
                        w_chip_n = r_chip + 2'd1;
                        // chips 1 and 2 carry the data bit, chip 3 is high
                        w_dout_n = (r_chip == 2'd2) ? 1'b1 : w_cur_bit;
                    end
                end else begin
                    w_pre_n = r_pre + 1'b1;
                end
            end
            S_STOP: begin
                if (w_pre_last) begin
                    w_pre_n = '0;
                    if (r_chip == 2'd0) begin
                        w_chip_n = 2'd1;
                        w_dout_n = 1'b1;
                    end else begin
                        w_chip_n  = 2'd0;
                        w_state_n = S_IDLE;
                        w_en_n    = 1'b0;
                        w_dout_n  = 1'b1;
                        w_done_n  = 1'b1;
                    end
                end else begin
                    w_pre_n = r_pre + 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_en_n    = 1'b0;
                w_dout_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_last  <= '0;
            r_pre   <= '0;
            r_chip  <= 2'd0;
            r_bit   <= 3'd0;
            r_byte  <= '0;
            r_en    <= 1'b0;
            r_dout  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pre   <= w_pre_n;
            r_chip  <= w_chip_n;
            r_bit   <= w_bit_n;
            r_byte  <= w_byte_n;
            r_en    <= w_en_n;
            r_dout  <= w_dout_n;
            r_done  <= w_done_n;
            r_err   <= w_err_n;
            if (w_latch) begin
                r_data <= cmd_data;
                r_last <= BW'(cmd_len - 1'b1);
            end
        end
    end

    assign busy     = r_en;
    assign enable_o = r_en;
    assign dout     = r_dout;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_n64_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n64_cmd_tx
//  Purpose  : Self-checking bench for n64_cmd_tx. Instance 0 uses
//             MAX_BYTES=3, CLKS_PER_CHIP=1; instance 1 uses MAX_BYTES=2,
//             CLKS_PER_CHIP=4. Expected line waveforms are built from the
//             chip-encoding rules into a queue of levels, one per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_n64_cmd_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        st   [2];
    logic [23:0] cd   [2];
    logic [1:0]  cl   [2];
    logic        busy [2];
    logic        en   [2];
    logic        dout [2];
    logic        done [2];
    logic        err  [2];

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    n64_cmd_tx #(.MAX_BYTES(3), .CLKS_PER_CHIP(1)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .start    (st[0]),
        .cmd_data (cd[0]),
        .cmd_len  (cl[0]),
        .busy     (busy[0]),
        .enable_o (en[0]),
        .dout     (dout[0]),
        .done     (done[0]),
        .err      (err[0])
    );

    n64_cmd_tx #(.MAX_BYTES(2), .CLKS_PER_CHIP(4)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (st[1]),
        .cmd_data (cd[1][15:0]),
        .cmd_len  (cl[1]),
        .busy     (busy[1]),
        .enable_o (en[1]),
        .dout     (dout[1]),
        .done     (done[1]),
        .err      (err[1])
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Expected line level for every enabled clock of a frame.
    task automatic build(input int u, input logic [23:0] d, input int len);
        int         cpc;
        logic [7:0] by;
        bit         lv [4];
        cpc = (u == 0) ? 1 : 4;
        exp_q.delete();
        for (int b = 0; b < len; b++) begin
            by = d[8*b +: 8];
            for (int k = 7; k >= 0; k--) begin
                lv[0] = 1'b0; lv[1] = by[k]; lv[2] = by[k]; lv[3] = 1'b1;
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < cpc; r++) exp_q.push_back(lv[c]);
            end
        end
        for (int r = 0; r < cpc; r++) exp_q.push_back(1'b0);
        for (int r = 0; r < cpc; r++) exp_q.push_back(1'b1);
    endtask

    task automatic launch(input int u, input logic [23:0] d, input logic [1:0] len);
        @(posedge clk); #1;
        st[u] = 1'b1; cd[u] = d; cl[u] = len;
        @(posedge clk); #1;
        st[u] = 1'b0;
    endtask

    // Follows one frame cycle by cycle. Inputs are scrambled while busy,
    // optionally with a start pulse at inject_at; reset_at aborts the frame;
    // chain issues a new start in the done cycle.
    task automatic observe(input int u, input int inject_at, input int reset_at,
                           input bit chain, input logic [23:0] nd, input logic [1:0] nl);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            chk("enable", i, 32'(en[u]),   32'd1);
            chk("dout",   i, 32'(dout[u]), 32'(exp_q[i]));
            chk("busy",   i, 32'(busy[u]), 32'd1);
            chk("done",   i, 32'(done[u]), 32'd0);
            chk("err",    i, 32'(err[u]),  32'd0);
            if (i == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("rst_enable", i, 32'(en[u]),   32'd0);
                chk("rst_dout",   i, 32'(dout[u]), 32'd1);
                chk("rst_busy",   i, 32'(busy[u]), 32'd0);
                chk("rst_done",   i, 32'(done[u]), 32'd0);
                reset = 1'b0;
                @(negedge clk);
                chk("post_rst_done",   i, 32'(done[u]), 32'd0);
                chk("post_rst_enable", i, 32'(en[u]),   32'd0);
                chk("post_rst_dout",   i, 32'(dout[u]), 32'd1);
                return;
            end
            cd[u] = 24'($urandom);
            cl[u] = 2'($urandom);
            st[u] = (i == inject_at);
        end
        st[u] = 1'b0;
        @(negedge clk);
        chk("end_enable", u, 32'(en[u]),   32'd0);
        chk("end_dout",   u, 32'(dout[u]), 32'd1);
        chk("end_busy",   u, 32'(busy[u]), 32'd0);
        chk("end_done",   u, 32'(done[u]), 32'd1);
        chk("end_err",    u, 32'(err[u]),  32'd0);
        if (chain) begin
            st[u] = 1'b1; cd[u] = nd; cl[u] = nl;
            @(posedge clk); #1;
            st[u] = 1'b0;
        end else begin
            @(negedge clk);
            chk("done_once", u, 32'(done[u]), 32'd0);
            chk("idle_dout", u, 32'(dout[u]), 32'd1);
        end
    endtask

    task automatic bad_len(input int u, input logic [1:0] len);
        launch(u, 24'($urandom), len);
        @(negedge clk);
        chk("err_pulse",  u, 32'(err[u]),  32'd1);
        chk("err_enable", u, 32'(en[u]),   32'd0);
        chk("err_busy",   u, 32'(busy[u]), 32'd0);
        chk("err_dout",   u, 32'(dout[u]), 32'd1);
        @(negedge clk);
        chk("err_clear",  u, 32'(err[u]),  32'd0);
        chk("err_idle",   u, 32'(en[u]),   32'd0);
    endtask

    initial begin
        logic [23:0] d, d2;
        int          len;

        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            st[u] = 1'b0; cd[u] = '0; cl[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy",   u, 32'(busy[u]), 32'd0);
            chk("rst_enable", u, 32'(en[u]),   32'd0);
            chk("rst_dout",   u, 32'(dout[u]), 32'd1);
            chk("rst_done",   u, 32'(done[u]), 32'd0);
            chk("rst_err",    u, 32'(err[u]),  32'd0);
        end

        // Single byte 0x01 at one clock per chip: 34 enabled cycles
        build(0, 24'h000001, 1);
        chk("len_1byte", 0, 32'(exp_q.size()), 32'd34);
        launch(0, 24'h000001, 2'd1);
        observe(0, -1, -1, 1'b0, '0, '0);

        // Three bytes 0x02, 0x80, 0x01: 98 enabled cycles
        build(0, 24'h018002, 3);
        chk("len_3byte", 0, 32'(exp_q.size()), 32'd98);
        launch(0, 24'h018002, 2'd3);
        observe(0, -1, -1, 1'b0, '0, '0);

        // 0xFF at four clocks per chip: 136 enabled cycles
        build(1, 24'h0000FF, 1);
        chk("len_cpc4", 1, 32'(exp_q.size()), 32'd136);
        launch(1, 24'h0000FF, 2'd1);
        observe(1, -1, -1, 1'b0, '0, '0);

        // Start mid-frame is ignored; start in the done cycle chains a frame
        d  = 24'($urandom);
        d2 = 24'($urandom);
        build(0, d, 2);
        launch(0, d, 2'd2);
        observe(0, 5, -1, 1'b1, d2, 2'd3);
        build(0, d2, 3);
        observe(0, 20, -1, 1'b0, '0, '0);

        // Rejected lengths
        bad_len(0, 2'd0);
        bad_len(1, 2'd0);
        bad_len(1, 2'd3);

        // Reset during a frame, then a clean frame
        d = 24'($urandom);
        build(0, d, 2);
        launch(0, d, 2'd2);
        observe(0, -1, 10, 1'b0, '0, '0);
        d = 24'($urandom);
        build(0, d, 1);
        launch(0, d, 2'd1);
        observe(0, -1, -1, 1'b0, '0, '0);

        // Randomized frames on both instances
        for (int n = 0; n < 4; n++) begin
            d   = 24'($urandom);
            len = int'($urandom_range(1, 3));
            build(0, d, len);
            launch(0, d, 2'(len));
            observe(0, int'($urandom_range(0, 30)), -1, 1'b0, '0, '0);
        end
        for (int n = 0; n < 2; n++) begin
            d   = 24'($urandom);
            len = int'($urandom_range(1, 2));
            build(1, d, len);
            launch(1, d, 2'(len));
            observe(1, int'($urandom_range(0, 60)), -1, 1'b0, '0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
